// File: rtl/cw305_reg_ml_mac.sv
// cw305_reg_ml_mac: register-bus programmable dense layer (signed MAC with saturation/ReLU)
module cw305_reg_ml_mac #(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pADDR_WIDTH   = 21,
    parameter int pINPUTCNT     = 4,
    parameter int pOUTPUTCNT    = 4,
    parameter int pDATA_WIDTH   = 8,
    parameter int pACC_WIDTH    = 24
) (
    input  logic                                 usb_clk,
    input  logic                                 resetn,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    input  logic [7:0]                           write_data,
    output logic [7:0]                           read_data,
    input  logic                                 reg_read,
    input  logic                                 reg_write,
    input  logic                                 reg_addrvalid,
    output logic                                 trigger
);
    localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int DB = pDATA_WIDTH / 8;
    localparam int AB = pACC_WIDTH / 8;
    localparam int NW = pINPUTCNT * pOUTPUTCNT;
    localparam int PW = 2 * pDATA_WIDTH;
    localparam int SW = pACC_WIDTH + 1;
    localparam int IW = pINPUTCNT > 1 ? $clog2(pINPUTCNT) : 1;
    localparam int OW = pOUTPUTCNT > 1 ? $clog2(pOUTPUTCNT) : 1;
    localparam logic [AW-1:0] A_IN = AW'(0), A_W = AW'(1), A_B = AW'(2), A_OUT = AW'(3);
    localparam logic [AW-1:0] A_CTRL = AW'(4), A_STAT = AW'(5), A_CYC = AW'(6);
    localparam logic signed [pACC_WIDTH-1:0] MAXV = {1'b0, {(pACC_WIDTH-1){1'b1}}};
    localparam logic signed [pACC_WIDTH-1:0] MINV = {1'b1, {(pACC_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, MAC, STORE, DONE} state_e;

    state_e                         state_q;
    logic signed [pDATA_WIDTH-1:0]  x_q [pINPUTCNT];
    logic signed [pDATA_WIDTH-1:0]  w_q [NW];
    logic signed [pACC_WIDTH-1:0]   b_q [pOUTPUTCNT];
    logic signed [pACC_WIDTH-1:0]   out_q [pOUTPUTCNT];
    logic signed [pACC_WIDTH-1:0]   acc_q;
    logic [IW-1:0]                  i_q;
    logic [OW-1:0]                  o_q;
    logic                           busy_q, done_q, ovf_q, relu_q;
    logic [15:0]                    cyc_q;
    logic [7:0]                     rd_q, rd_d;

    logic signed [pDATA_WIDTH-1:0]  x_s, w_s;
    logic signed [pACC_WIDTH-1:0]   b_s, sat;
    logic signed [PW-1:0]           prod;
    logic signed [SW-1:0]           sum;
    logic                           wr, ctrl_wr, go, ovf_now;

    assign wr      = reg_addrvalid & reg_write & ~busy_q;
    assign ctrl_wr = wr & (reg_address == A_CTRL) & (reg_bytecnt == '0);
    assign go      = ctrl_wr & write_data[0];

    always_comb begin
        x_s = '0;
        w_s = '0;
        b_s = '0;
        for (int k = 0; k < pINPUTCNT; k++) if (int'(i_q) == k) x_s = x_q[k];
        for (int k = 0; k < NW; k++) if (int'(o_q) * pINPUTCNT + int'(i_q) == k) w_s = w_q[k];
        for (int k = 0; k < pOUTPUTCNT; k++) if (int'(o_q) == k) b_s = b_q[k];
    end

    // sum is one bit wider than the accumulator so overflow shows as a sign-bit disagreement
    assign prod    = PW'(x_s) * PW'(w_s);
    assign sum     = SW'(acc_q) + SW'(prod);
    assign ovf_now = sum[SW-1] ^ sum[SW-2];
    assign sat     = ovf_now ? (sum[SW-1] ? MINV : MAXV) : sum[SW-2:0];

    always_comb begin
        rd_d = '0;
        for (int k = 0; k < pINPUTCNT; k++)
            for (int b = 0; b < DB; b++)
                if (reg_address == A_IN && int'(reg_bytecnt) == k*DB+b) rd_d = x_q[k][8*b +: 8];
        for (int k = 0; k < NW; k++)
            for (int b = 0; b < DB; b++)
                if (reg_address == A_W && int'(reg_bytecnt) == k*DB+b) rd_d = w_q[k][8*b +: 8];
        for (int k = 0; k < pOUTPUTCNT; k++)
            for (int b = 0; b < AB; b++) begin
                if (reg_address == A_B && int'(reg_bytecnt) == k*AB+b) rd_d = b_q[k][8*b +: 8];
                if (reg_address == A_OUT && int'(reg_bytecnt) == k*AB+b) rd_d = out_q[k][8*b +: 8];
            end
        if (reg_address == A_CTRL && reg_bytecnt == '0) rd_d = {6'b0, relu_q, 1'b0};
        if (reg_address == A_STAT && reg_bytecnt == '0) rd_d = {5'b0, ovf_q, done_q, busy_q};
        if (reg_address == A_CYC && int'(reg_bytecnt) == 0) rd_d = cyc_q[7:0];
        if (reg_address == A_CYC && int'(reg_bytecnt) == 1) rd_d = cyc_q[15:8];
    end

    always_ff @(posedge usb_clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < pINPUTCNT; k++) x_q[k] <= '0;
            for (int k = 0; k < NW; k++) w_q[k] <= '0;
            for (int k = 0; k < pOUTPUTCNT; k++) b_q[k] <= '0;
            rd_q <= '0;
        end else begin
            for (int k = 0; k < pINPUTCNT; k++)
                for (int b = 0; b < DB; b++)
                    if (wr && reg_address == A_IN && int'(reg_bytecnt) == k*DB+b) x_q[k][8*b +: 8] <= write_data;
            for (int k = 0; k < NW; k++)
                for (int b = 0; b < DB; b++)
                    if (wr && reg_address == A_W && int'(reg_bytecnt) == k*DB+b) w_q[k][8*b +: 8] <= write_data;
            for (int k = 0; k < pOUTPUTCNT; k++)
                for (int b = 0; b < AB; b++)
                    if (wr && reg_address == A_B && int'(reg_bytecnt) == k*AB+b) b_q[k][8*b +: 8] <= write_data;
            if (reg_addrvalid && reg_read) rd_q <= rd_d;
        end
    end

    // busy and done change on the same edge so software never sees both low mid-run
    always_ff @(posedge usb_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            for (int k = 0; k < pOUTPUTCNT; k++) out_q[k] <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            o_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            relu_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            if (ctrl_wr) relu_q <= write_data[1];
            if (busy_q && cyc_q != 16'hFFFF) cyc_q <= cyc_q + 16'd1;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= go ? LOAD : IDLE;
                    if (go) begin
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        ovf_q  <= 1'b0;
                        cyc_q  <= '0;
                        o_q    <= '0;
                    end
                end
                LOAD: begin
                    acc_q   <= b_s;
                    i_q     <= '0;
                    state_q <= MAC;
                end
                MAC: begin
                    acc_q <= sat;
                    if (ovf_now) ovf_q <= 1'b1;
                    if (int'(i_q) == pINPUTCNT-1) state_q <= STORE;
                    else i_q <= i_q + IW'(1);
                end
                STORE: begin
                    for (int k = 0; k < pOUTPUTCNT; k++)
                        if (int'(o_q) == k) out_q[k] <= (relu_q && acc_q[pACC_WIDTH-1]) ? '0 : acc_q;
                    if (int'(o_q) == pOUTPUTCNT-1) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        o_q     <= o_q + OW'(1);
                        state_q <= LOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign read_data = rd_q;
    assign trigger   = busy_q;
endmodule

// File: tb/tb_cw305_reg_ml_mac.sv
// tb_cw305_reg_ml_mac: directed bench for the ML MAC register block with a read scoreboard
module tb_cw305_reg_ml_mac;
    logic        usb_clk = 1'b0, resetn = 1'b0;
    logic [13:0] reg_address = '0;
    logic [6:0]  reg_bytecnt = '0;
    logic [7:0]  write_data = '0, read_data;
    logic        reg_read = 1'b0, reg_write = 1'b0, reg_addrvalid = 1'b0, trigger;

    int          n_assert = 0, n_fail = 0;
    logic [7:0]  exp_q[$];
    string       tag_q[$];
    int          x[4], w[16], b[4];
    logic [23:0] mout[4];
    bit          movf;

    always #5 usb_clk = ~usb_clk;

    cw305_reg_ml_mac dut (
        .usb_clk(usb_clk), .resetn(resetn), .reg_address(reg_address),
        .reg_bytecnt(reg_bytecnt), .write_data(write_data), .read_data(read_data),
        .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid),
        .trigger(trigger)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic wr8(input int a, input int bc, input logic [7:0] d);
        @(negedge usb_clk);
        reg_address = 14'(a); reg_bytecnt = 7'(bc); write_data = d;
        reg_addrvalid = 1'b1; reg_write = 1'b1;
        @(negedge usb_clk);
        reg_addrvalid = 1'b0; reg_write = 1'b0;
    endtask

    task automatic rd8(input int a, input int bc, input logic [7:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge usb_clk);
        reg_address = 14'(a); reg_bytecnt = 7'(bc);
        reg_addrvalid = 1'b1; reg_read = 1'b1;
        @(negedge usb_clk);
        reg_addrvalid = 1'b0; reg_read = 1'b0;
        chk(tag_q.pop_front(), {24'b0, read_data}, {24'b0, exp_q.pop_front()});
    endtask

    task automatic wr_elem(input int a, input int k, input int nb, input logic [31:0] v);
        for (int i = 0; i < nb; i++) wr8(a, k*nb+i, v[8*i +: 8]);
    endtask

    task automatic rd_elem(input int a, input int k, input int nb, input logic [31:0] e, input string tag);
        for (int i = 0; i < nb; i++) rd8(a, k*nb+i, e[8*i +: 8], $sformatf("%s_b%0d", tag, i));
    endtask

    task automatic load_all();
        for (int i = 0; i < 4; i++) wr_elem(0, i, 1, 32'(x[i]));
        for (int i = 0; i < 16; i++) wr_elem(1, i, 1, 32'(w[i]));
        for (int i = 0; i < 4; i++) wr_elem(2, i, 3, 32'(b[i]));
    endtask

    task automatic model(input bit relu);
        longint acc;
        movf = 1'b0;
        for (int o = 0; o < 4; o++) begin
            acc = b[o];
            for (int i = 0; i < 4; i++) begin
                acc = acc + longint'(x[i]) * longint'(w[o*4+i]);
                if (acc > 64'sd8388607) begin acc = 8388607; movf = 1'b1; end
                if (acc < -64'sd8388608) begin acc = -8388608; movf = 1'b1; end
            end
            mout[o] = (relu && acc < 0) ? 24'd0 : acc[23:0];
        end
    endtask

    task automatic check_outs(input string tag);
        for (int o = 0; o < 4; o++) rd_elem(3, o, 3, {8'b0, mout[o]}, $sformatf("%s_out%0d", tag, o));
    endtask

    task automatic run(input logic [7:0] ctrl, input string tag);
        int n = 0;
        wr8(4, 0, ctrl);
        while (trigger === 1'b1 && n < 200) begin
            n++;
            @(negedge usb_clk);
        end
        chk({tag, "_trig_cycles"}, n, 24);
        rd8(5, 0, {5'b0, movf, 2'b10}, {tag, "_status"});
        rd8(6, 0, 8'd24, {tag, "_cyc_lo"});
        rd8(6, 1, 8'd0, {tag, "_cyc_hi"});
    endtask

    initial begin
        repeat (3) @(negedge usb_clk);
        chk("rst_trigger", {31'b0, trigger}, 0);
        chk("rst_read_data", {24'b0, read_data}, 0);
        resetn = 1'b1;
        rd8(5, 0, 8'h00, "rst_status");
        rd8(4, 0, 8'h00, "rst_ctrl");
        rd8(6, 0, 8'h00, "rst_cycles");
        rd_elem(3, 0, 3, 0, "rst_out0");

        // identity
        for (int i = 0; i < 4; i++) begin x[i] = i + 1; b[i] = 0; end
        for (int i = 0; i < 16; i++) w[i] = (i / 4 == i % 4) ? 1 : 0;
        load_all();
        rd8(0, 2, 8'h03, "rb_x2");
        rd8(1, 5, 8'h01, "rb_w5");
        model(1'b0);
        run(8'h01, "id");
        check_outs("id");

        // all weights -1, bias 5
        for (int i = 0; i < 16; i++) w[i] = -1;
        for (int i = 0; i < 4; i++) b[i] = 5;
        load_all();
        model(1'b0);
        run(8'h01, "neg");
        check_outs("neg");
        rd_elem(3, 2, 3, 32'h00FFFFFB, "neg_const");

        // same data with ReLU
        model(1'b1);
        run(8'h03, "relu");
        check_outs("relu");
        rd8(4, 0, 8'h02, "relu_ctrl");

        // saturation then recovery
        for (int i = 0; i < 4; i++) begin x[i] = 127; b[i] = 0; end
        for (int i = 0; i < 16; i++) w[i] = 127;
        b[0] = 32'h7FFFF0;
        load_all();
        model(1'b0);
        run(8'h01, "sat");
        rd_elem(3, 0, 3, 32'h007FFFFF, "sat_out0");
        b[0] = 0;
        wr_elem(2, 0, 3, 0);
        model(1'b0);
        run(8'h01, "unsat");
        rd_elem(3, 0, 3, 32'h0000FC04, "unsat_out0");

        // busy lockout
        begin
            int n = 0;
            wr8(4, 0, 8'h01);
            wr8(0, 0, 8'h09);
            wr8(4, 0, 8'h03);
            rd8(5, 0, 8'h01, "lock_status_busy");
            while (trigger === 1'b1 && n < 200) begin
                n++;
                @(negedge usb_clk);
            end
            chk("lock_trig_end", {31'b0, trigger}, 0);
            rd8(6, 0, 8'd24, "lock_cyc");
            rd8(0, 0, 8'h7F, "lock_x0");
            rd8(4, 0, 8'h00, "lock_ctrl");
            rd8(5, 0, 8'h02, "lock_status");
            check_outs("lock");
        end

        // boundaries
        wr8(1, 16, 8'h55);
        rd8(1, 16, 8'h00, "oob_w16");
        rd8(1, 15, 8'h7F, "w15_intact");
        rd8(7, 0, 8'h00, "undef_addr");
        rd8(5, 1, 8'h00, "status_b1");

        // reset mid-run
        wr8(4, 0, 8'h01);
        repeat (3) @(negedge usb_clk);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_trigger", {31'b0, trigger}, 0);
        chk("mid_rst_read_data", {24'b0, read_data}, 0);
        @(negedge usb_clk);
        resetn = 1'b1;
        rd8(5, 0, 8'h00, "post_rst_status");
        rd8(6, 0, 8'h00, "post_rst_cyc");
        rd8(0, 0, 8'h00, "post_rst_x0");
        rd8(1, 0, 8'h00, "post_rst_w0");
        rd8(2, 0, 8'h00, "post_rst_b0");
        rd_elem(3, 0, 3, 0, "post_rst_out0");
        chk("post_rst_trigger", {31'b0, trigger}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
